// File: rtl/befehls_steuerwerk.sv
`default_nettype none
// ============================================================================
// Module      : befehls_steuerwerk
// Description : Multi-cycle control unit of the Hans core. Owns the program
//               counter, fetches over the shared request/ready memory port,
//               strobes the decoder, waits out the ALU, runs the load/store
//               memory phase, and issues register write-back and the next-PC
//               selection from the decoder's classification flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC     PC value after reset (word address)
//   ALU_LATENZ   execute-phase cycles, 1..15
//   MEM_TIMEOUT  max wait cycles per memory access before error, 1..255
// Ports
//   Takt, Reset                      clock (rising edge), async active-high reset
//   Anhalten                         debug stop, honoured before the next fetch
//   SpeicherBereit                   memory ready for the current request
//   LoadBefehl .. Sprungbedingung    decoder classification flags
//   IDaten                           decoder immediate (jump offset)
//   Quellwert1                       source-1 register value (branch test, Jreg)
//   SpeicherAnfrage/Schreiben        memory request / write qualifier
//   AdressWahl                       0 = PC address, 1 = ALU result address
//   DekodierSignal                   one-cycle decode strobe
//   RegisterSchreiben, DatenWahl     register write enable / write-back source
//   Befehlszaehler                   current PC
//   Fehler                           sticky memory-timeout error
// ============================================================================
module befehls_steuerwerk #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned ALU_LATENZ  = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        Takt,
    input  logic        Reset,
    input  logic        Anhalten,
    input  logic        SpeicherBereit,
    input  logic        LoadBefehl,
    input  logic        StoreBefehl,
    input  logic        UnbedingterSprungBefehl,
    input  logic        BedingterSprungBefehl,
    input  logic        JALBefehl,
    input  logic        RelativerSprung,
    input  logic        AbsoluterSprung,
    input  logic        Sprungbedingung,
    input  logic [31:0] IDaten,
    input  logic [31:0] Quellwert1,
    output logic        SpeicherAnfrage,
    output logic        SpeicherSchreiben,
    output logic        AdressWahl,
    output logic        DekodierSignal,
    output logic        RegisterSchreiben,
    output logic [1:0]  DatenWahl,
    output logic [31:0] Befehlszaehler,
    output logic        Fehler
);

    typedef enum logic [2:0] {
        LEERLAUF       = 3'd0,
        HOLEN          = 3'd1,
        DEKODIEREN     = 3'd2,
        AUSFUEHREN     = 3'd3,
        SPEICHER       = 3'd4,
        RUECKSCHREIBEN = 3'd5,
        FEHLER         = 3'd6
    } state_t;

    // The latency counter is loaded with LATENZ-1 so that "counter == 0"
    // marks the last execute cycle.
    localparam logic [3:0] c_LAT_RELOAD = 4'(ALU_LATENZ - 1);
    localparam logic [8:0] c_TIMEOUT    = 9'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_lat_cnt;
    logic [7:0]  r_to_cnt;
    logic [31:0] r_pc;

    logic        r_anfrage;
    logic        r_schreiben;
    logic        r_adress_wahl;
    logic        r_dekodier;
    logic        r_fehler;

    logic        w_mem_phase;
    logic        w_timeout;
    logic        w_rueck;
    logic        w_bed_erfuellt;
    logic        w_taken_rel;
    logic [31:0] w_pc_inc;
    logic [31:0] w_pc_rel;
    logic [31:0] w_next_pc;

    assign w_mem_phase = (r_state == HOLEN) || (r_state == SPEICHER);
    assign w_rueck     = (r_state == RUECKSCHREIBEN);

    // The wait in progress would be the MEM_TIMEOUT-th one. Ready is tested
    // before this in the next-state logic, so a late ready still wins.
    assign w_timeout = ({1'b0, r_to_cnt} + 9'd1) >= c_TIMEOUT;

    // ------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------
    assign w_pc_inc       = r_pc + 32'd1;
    assign w_pc_rel       = r_pc + IDaten;
    assign w_bed_erfuellt = ((Quellwert1 == 32'd0) == Sprungbedingung);
    assign w_taken_rel    = (UnbedingterSprungBefehl && RelativerSprung) ||
                            (BedingterSprungBefehl && w_bed_erfuellt);

    always_comb begin
        w_next_pc = w_pc_inc;
        if (AbsoluterSprung) begin
            w_next_pc = Quellwert1;
        end else if (w_taken_rel) begin
            w_next_pc = w_pc_rel;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LEERLAUF: begin
                if (!Anhalten) begin
                    w_next_state = HOLEN;
                end
            end
            HOLEN: begin
                if (SpeicherBereit) begin
                    w_next_state = DEKODIEREN;
                end else if (w_timeout) begin
                    w_next_state = FEHLER;
                end
            end
            DEKODIEREN: begin
                w_next_state = AUSFUEHREN;
            end
            AUSFUEHREN: begin
                if (r_lat_cnt == 4'd0) begin
                    w_next_state = (LoadBefehl || StoreBefehl) ? SPEICHER : RUECKSCHREIBEN;
                end
            end
            SPEICHER: begin
                if (SpeicherBereit) begin
                    w_next_state = RUECKSCHREIBEN;
                end else if (w_timeout) begin
                    w_next_state = FEHLER;
                end
            end
            RUECKSCHREIBEN: begin
                w_next_state = Anhalten ? LEERLAUF : HOLEN;
            end
            FEHLER: begin
                w_next_state = FEHLER;
            end
            default: begin
                w_next_state = LEERLAUF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters, PC and registered (Moore) outputs. Outputs are
    // computed from the next state so they are valid for the whole of the
    // state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge Takt or posedge Reset) begin
        if (Reset) begin
            r_state       <= LEERLAUF;
            r_lat_cnt     <= 4'd0;
            r_to_cnt      <= 8'd0;
            r_pc          <= RESET_PC;
            r_anfrage     <= 1'b0;
            r_schreiben   <= 1'b0;
            r_adress_wahl <= 1'b0;
            r_dekodier    <= 1'b0;
            r_fehler      <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (r_state == DEKODIEREN) begin
                r_lat_cnt <= c_LAT_RELOAD;
            end else if ((r_state == AUSFUEHREN) && (r_lat_cnt != 4'd0)) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end

            // Any state change clears the wait counter, which covers every
            // entry into HOLEN or SPEICHER.
            if (w_next_state != r_state) begin
                r_to_cnt <= 8'd0;
            end else if (w_mem_phase && !SpeicherBereit) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end

            if (w_rueck) begin
                r_pc <= w_next_pc;
            end

            r_anfrage     <= (w_next_state == HOLEN) || (w_next_state == SPEICHER);
            r_schreiben   <= (w_next_state == SPEICHER) && StoreBefehl;
            r_adress_wahl <= (w_next_state == SPEICHER);
            r_dekodier    <= (w_next_state == DEKODIEREN);
            r_fehler      <= (w_next_state == FEHLER);
        end
    end

    // ------------------------------------------------------------------
    // Write-back controls: the only outputs that follow the decoder flags
    // combinationally, and only while in RUECKSCHREIBEN.
    // ------------------------------------------------------------------
    assign RegisterSchreiben = w_rueck &&
                               !(StoreBefehl || BedingterSprungBefehl ||
                                 (UnbedingterSprungBefehl && !JALBefehl));

    always_comb begin
        DatenWahl = 2'd0;
        if (w_rueck) begin
            if (JALBefehl) begin
                DatenWahl = 2'd2;
            end else if (LoadBefehl) begin
                DatenWahl = 2'd1;
            end
        end
    end

    assign SpeicherAnfrage   = r_anfrage;
    assign SpeicherSchreiben = r_schreiben;
    assign AdressWahl        = r_adress_wahl;
    assign DekodierSignal    = r_dekodier;
    assign Befehlszaehler    = r_pc;
    assign Fehler            = r_fehler;

endmodule
`default_nettype wire

// File: tb/tb_befehls_steuerwerk.sv
`default_nettype none
// ============================================================================
// Module      : tb_befehls_steuerwerk
// Description : Self-checking bench for befehls_steuerwerk. Acts as memory
//               and decoder; each instruction is turned into an expected
//               per-cycle output sequence derived from the phase rules, and
//               the DUT is compared against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_befehls_steuerwerk;

    localparam logic [31:0] RESET_PC    = 32'h0;
    localparam int          ALU_LATENZ  = 1;
    localparam int          MEM_TIMEOUT = 4;

    localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3;
    localparam int C_J = 4, C_JAL = 5, C_JREG = 6, C_JALR = 7;

    logic        Takt = 1'b0;
    logic        Reset = 1'b0;
    logic        Anhalten = 1'b0;
    logic        SpeicherBereit = 1'b0;
    logic        LoadBefehl = 1'b0, StoreBefehl = 1'b0;
    logic        UnbedingterSprungBefehl = 1'b0, BedingterSprungBefehl = 1'b0;
    logic        JALBefehl = 1'b0, RelativerSprung = 1'b0;
    logic        AbsoluterSprung = 1'b0, Sprungbedingung = 1'b0;
    logic [31:0] IDaten = 32'd0, Quellwert1 = 32'd0;
    logic        SpeicherAnfrage, SpeicherSchreiben, AdressWahl, DekodierSignal;
    logic        RegisterSchreiben, Fehler;
    logic [1:0]  DatenWahl;
    logic [31:0] Befehlszaehler;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_pc = RESET_PC;

    // Decoder view of the instruction currently in flight
    logic        f_ld, f_st, f_unb, f_bed, f_jal, f_rel, f_abs, f_cnd;
    logic [31:0] f_imm, f_q1;

    always #5 Takt = ~Takt;

    befehls_steuerwerk #(
        .RESET_PC    (RESET_PC),
        .ALU_LATENZ  (ALU_LATENZ),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .Takt                    (Takt),
        .Reset                   (Reset),
        .Anhalten                (Anhalten),
        .SpeicherBereit          (SpeicherBereit),
        .LoadBefehl              (LoadBefehl),
        .StoreBefehl             (StoreBefehl),
        .UnbedingterSprungBefehl (UnbedingterSprungBefehl),
        .BedingterSprungBefehl   (BedingterSprungBefehl),
        .JALBefehl               (JALBefehl),
        .RelativerSprung         (RelativerSprung),
        .AbsoluterSprung         (AbsoluterSprung),
        .Sprungbedingung         (Sprungbedingung),
        .IDaten                  (IDaten),
        .Quellwert1              (Quellwert1),
        .SpeicherAnfrage         (SpeicherAnfrage),
        .SpeicherSchreiben       (SpeicherSchreiben),
        .AdressWahl              (AdressWahl),
        .DekodierSignal          (DekodierSignal),
        .RegisterSchreiben       (RegisterSchreiben),
        .DatenWahl               (DatenWahl),
        .Befehlszaehler          (Befehlszaehler),
        .Fehler                  (Fehler)
    );

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic coin();
        return 1'($urandom);
    endfunction

    // {req, wr, adr, dek, rs, dw[1:0], fehler}
    function automatic logic [7:0] obs();
        return {SpeicherAnfrage, SpeicherSchreiben, AdressWahl, DekodierSignal,
                RegisterSchreiben, DatenWahl, Fehler};
    endfunction

    task automatic drive_flags(input bit valid);
        if (valid) begin
            LoadBefehl = f_ld; StoreBefehl = f_st;
            UnbedingterSprungBefehl = f_unb; BedingterSprungBefehl = f_bed;
            JALBefehl = f_jal; RelativerSprung = f_rel;
            AbsoluterSprung = f_abs; Sprungbedingung = f_cnd;
            IDaten = f_imm; Quellwert1 = f_q1;
        end else begin
            {LoadBefehl, StoreBefehl, UnbedingterSprungBefehl, BedingterSprungBefehl,
             JALBefehl, RelativerSprung, AbsoluterSprung, Sprungbedingung} = 8'($urandom);
            IDaten = $urandom;
            Quellwert1 = $urandom;
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then check.
    // Write/address selects are only meaningful while a request is expected,
    // DatenWahl only during write-back.
    task automatic cyc(input string tag, input logic [7:0] ev, input bit wb,
                       input logic rdy, input logic anh, input bit valid);
        logic [7:0] care;
        @(negedge Takt);
        SpeicherBereit = rdy;
        Anhalten = anh;
        drive_flags(valid);
        #1;
        care = 8'b1001_1001;
        if (ev[7]) care |= 8'b0110_0000;
        if (wb) care |= 8'b0000_0110;
        chk_val(tag, 32'(obs() & care), 32'(ev & care));
        chk_val({tag, "_pc"}, Befehlszaehler, model_pc);
    endtask

    // Asserts Reset away from any clock edge, checks the immediate effect,
    // then releases it on a falling edge leaving the DUT in its idle cycle.
    task automatic do_reset();
        #2 Reset = 1'b1;
        #1;
        chk_val("rst_out", 32'(obs()), 32'd0);
        chk_val("rst_pc", Befehlszaehler, RESET_PC);
        model_pc = RESET_PC;
        @(negedge Takt);
        drive_flags(0);
        SpeicherBereit = coin();
        Anhalten = 1'b0;
        #1;
        chk_val("rst_hold", 32'(obs()), 32'd0);
        Reset = 1'b0;
        #1;
        chk_val("idle_out", 32'(obs() & 8'b1001_1001), 32'd0);
        chk_val("idle_pc", Befehlszaehler, RESET_PC);
    endtask

    task automatic run_instr(input int cls, input int df, input int dm, input bit halt,
                             input int idle, input logic [31:0] imm, input logic [31:0] q1,
                             input bit cnd, input bit rst_mem);
        bit          mem, st, wr;
        logic [1:0]  dw;
        logic [31:0] npc;
        {f_ld, f_st, f_unb, f_bed, f_jal, f_rel, f_abs} = '0;
        f_cnd = cnd; f_imm = imm; f_q1 = q1;
        mem = 0; st = 0; wr = 0; dw = 2'd0;
        npc = model_pc + 32'd1;
        case (cls)
            C_ALU: wr = 1;
            C_LD:  begin f_ld = 1; mem = 1; wr = 1; dw = 2'd1; end
            C_ST:  begin f_st = 1; mem = 1; st = 1; end
            C_BR:  begin
                f_bed = 1; f_rel = 1;
                // cnd=1 is "branch if zero", cnd=0 "branch if not zero"
                if (cnd ? (q1 == 32'd0) : (q1 != 32'd0)) npc = model_pc + imm;
            end
            C_J:    begin f_unb = 1; f_rel = 1; npc = model_pc + imm; end
            C_JAL:  begin f_unb = 1; f_jal = 1; f_rel = 1; wr = 1; dw = 2'd2; npc = model_pc + imm; end
            C_JREG: begin f_unb = 1; f_abs = 1; npc = q1; end
            default: begin f_unb = 1; f_jal = 1; f_abs = 1; wr = 1; dw = 2'd2; npc = q1; end
        endcase

        for (int k = 0; k <= df; k++) cyc("fetch", 8'b1000_0000, 0, k == df, coin(), 0);
        cyc("decode", 8'b0001_0000, 0, coin(), coin(), 0);
        for (int k = 0; k < ALU_LATENZ; k++) cyc("exec", 8'b0, 0, coin(), halt ? 1'b1 : coin(), 1);
        if (mem) begin
            for (int k = 0; k <= dm; k++) begin
                cyc("mem", {1'b1, st, 1'b1, 5'b0}, 0, k == dm, coin(), 1);
                if (rst_mem && k == 1) begin
                    do_reset();
                    return;
                end
            end
        end
        cyc("wb", {4'b0, wr, dw, 1'b0}, 1, coin(), halt, 1);
        model_pc = npc;
        if (halt) begin
            for (int k = 0; k < idle; k++) cyc("halt", 8'b0, 0, coin(), 1'b1, 0);
            cyc("resume", 8'b0, 0, coin(), 1'b0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cls, df, dm, idle;
        bit          halt, cnd;
        logic [31:0] imm, q1;

        do_reset();

        // Directed sequence
        run_instr(C_ALU,  0, 0, 0, 0, 32'd0, 32'd0, 0, 0);          // 0 -> 1
        run_instr(C_LD,   0, 3, 0, 0, 32'd0, 32'd0, 0, 0);          // load, late ready
        run_instr(C_ST,   1, 2, 0, 0, 32'd0, 32'd0, 0, 0);          // store
        run_instr(C_ALU,  3, 0, 0, 0, 32'd0, 32'd0, 0, 0);          // ready on last wait
        run_instr(C_JREG, 0, 0, 0, 0, 32'd0, 32'd10, 0, 0);         // -> 10
        run_instr(C_BR,   0, 0, 0, 0, 32'hFFFF_FFFC, 32'd0, 1, 0);  // Bez taken -> 6
        run_instr(C_JREG, 0, 0, 0, 0, 32'd0, 32'd10, 0, 0);
        run_instr(C_BR,   0, 0, 0, 0, 32'hFFFF_FFFC, 32'd5, 1, 0);  // Bez not taken -> 11
        run_instr(C_JREG, 0, 0, 0, 0, 32'd0, 32'd10, 0, 0);
        run_instr(C_BR,   0, 0, 0, 0, 32'hFFFF_FFFC, 32'd5, 0, 0);  // BNez taken -> 6
        run_instr(C_JREG, 0, 0, 0, 0, 32'd0, 32'd10, 0, 0);
        run_instr(C_BR,   0, 0, 0, 0, 32'hFFFF_FFFC, 32'd0, 0, 0);  // BNez not taken -> 11
        run_instr(C_JREG, 0, 0, 0, 0, 32'd0, 32'd10, 0, 0);
        run_instr(C_JAL,  0, 0, 0, 0, 32'd3, 32'd0, 0, 0);          // -> 13, link
        run_instr(C_JREG, 0, 0, 0, 0, 32'd0, 32'h40, 0, 0);         // -> 0x40
        run_instr(C_JREG, 0, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, 0, 0);
        run_instr(C_ALU,  0, 0, 0, 0, 32'd0, 32'd0, 0, 0);          // wraps to 0
        run_instr(C_JALR, 0, 0, 0, 0, 32'd0, 32'h123, 0, 0);
        run_instr(C_ALU,  0, 0, 1, 3, 32'd0, 32'd0, 0, 0);          // halt during execute

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            cls  = $urandom_range(0, 7);
            df   = $urandom_range(0, MEM_TIMEOUT - 1);
            dm   = $urandom_range(0, MEM_TIMEOUT - 1);
            halt = ($urandom_range(0, 7) == 0);
            idle = $urandom_range(0, 3);
            cnd  = coin();
            q1   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            imm  = coin() ? (32'($urandom_range(0, 15)) - 32'd8) : 32'($urandom);
            run_instr(cls, df, dm, halt, idle, imm, q1, cnd, 0);
        end

        // Reset in the middle of a load's memory phase
        run_instr(C_LD,  0, 3, 0, 0, 32'd0, 32'd0, 0, 1);
        run_instr(C_ALU, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0);

        // Fetch never acknowledged: error after MEM_TIMEOUT wait cycles
        for (int k = 0; k < MEM_TIMEOUT; k++) cyc("to_fetch", 8'b1000_0000, 0, 1'b0, coin(), 0);
        for (int k = 0; k < 5; k++) cyc("to_err", 8'b0000_0001, 0, coin(), coin(), 0);
        do_reset();
        run_instr(C_ALU, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/befehls_steuerwerk.md
Name: befehls_steuerwerk

Overview:
Multi-cycle control unit for the Hans core. It owns the program counter, fetches instructions over a shared request/ready memory port, and pulses the decode strobe into the instruction decoder. It waits out the ALU, runs the load/store memory phase, and issues register write-back and next-PC selection from the decoder's classification flags. It is the single sequencer between instruction memory, decoder, ALU and register file.

Parameters:
RESET_PC, 32'h0, PC value after reset (word address)
ALU_LATENZ, 1, execute-phase cycles, range 1..15
MEM_TIMEOUT, 255, max wait cycles for SpeicherBereit per access before error, range 1..255

Ports:
Takt  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high
Anhalten  in  1  hold in LEERLAUF before next fetch (debug stop)
SpeicherBereit  in  1  memory ready/acknowledge for current request
LoadBefehl, StoreBefehl, UnbedingterSprungBefehl, BedingterSprungBefehl  in  1 each  decoder flags
JALBefehl, RelativerSprung, AbsoluterSprung, Sprungbedingung  in  1 each  decoder flags
IDaten  in  32  decoder immediate (jump offset)
Quellwert1  in  32  register-file value of source 1 (branch test, Jreg target)
SpeicherAnfrage  out  1  memory request
SpeicherSchreiben  out  1  1 = write access (valid with SpeicherAnfrage)
AdressWahl  out  1  0 = address from PC, 1 = address from ALU result
DekodierSignal  out  1  one-cycle decode strobe
RegisterSchreiben  out  1  one-cycle register-file write enable
DatenWahl  out  2  write-back source: 0 ALU, 1 memory, 2 link (PC+1)
Befehlszaehler  out  32  current PC
Fehler  out  1  sticky memory-timeout error

Behaviour:
- Reset asserted (any time, including mid-access): state LEERLAUF, Befehlszaehler=RESET_PC, latency and timeout counters 0, all strobes/selects/Fehler 0, DatenWahl=0. Outstanding memory access abandoned, no write-back.
- States: LEERLAUF, HOLEN, DEKODIEREN, AUSFUEHREN, SPEICHER, RUECKSCHREIBEN, FEHLER.
- LEERLAUF: all strobes 0. Anhalten=0 -> HOLEN next edge; otherwise stay.
- HOLEN: SpeicherAnfrage=1, SpeicherSchreiben=0, AdressWahl=0. Held until the edge sampling SpeicherBereit=1, then -> DEKODIEREN. Memory holds read data stable until its next request.
- DEKODIEREN: DekodierSignal=1 for exactly one cycle -> AUSFUEHREN. Decoder outputs are valid from the following cycle.
- AUSFUEHREN: stays exactly ALU_LATENZ cycles (counter reloaded on entry). Then -> SPEICHER if LoadBefehl|StoreBefehl, else -> RUECKSCHREIBEN.
- SPEICHER: SpeicherAnfrage=1, AdressWahl=1, SpeicherSchreiben=StoreBefehl. On SpeicherBereit=1 -> RUECKSCHREIBEN.
- RUECKSCHREIBEN, one cycle:
  - RegisterSchreiben=1 unless StoreBefehl, BedingterSprungBefehl, or (UnbedingterSprungBefehl & !JALBefehl).
  - DatenWahl: 2 if JALBefehl, 1 if LoadBefehl, else 0.
  - PC update at the end of the cycle. Link value = PC+1, computed from the pre-update PC.
  - Next state: LEERLAUF if Anhalten, else HOLEN.
- Next PC, modulo 2^32:
  - AbsoluterSprung: Quellwert1.
  - Taken relative jump: PC+IDaten. Taken when UnbedingterSprungBefehl & RelativerSprung, or BedingterSprungBefehl & ((Quellwert1==0)==Sprungbedingung).
  - Otherwise: PC+1.
  - Wrap-around at 32'hFFFFFFFF is silent.
- Timeout:
  - Counter clears on entry to HOLEN/SPEICHER and counts each cycle with SpeicherAnfrage=1 & SpeicherBereit=0.
  - Reaching MEM_TIMEOUT -> FEHLER: Fehler=1, all strobes 0, PC frozen. Only Reset leaves FEHLER.
  - SpeicherBereit in the same cycle the count reaches the limit: the ready wins and no error is raised.
- SpeicherBereit outside HOLEN/SPEICHER is ignored. Anhalten is sampled only in LEERLAUF and RUECKSCHREIBEN; an instruction in flight always completes.
- Outputs are Moore (from state register). Only RegisterSchreiben/DatenWahl depend combinationally on the decoder flags.

Test Plan:
- Reset release with Anhalten=0, ALU_LATENZ=1, SpeicherBereit always 1, ALU instruction -> HOLEN 1 cycle, DekodierSignal 1 cycle, AUSFUEHREN 1, RUECKSCHREIBEN with RegisterSchreiben=1, DatenWahl=0; PC 0->1; 4 cycles/instruction.
- Load with SpeicherBereit delayed 3 cycles in SPEICHER -> AdressWahl=1, SpeicherSchreiben=0 held 4 cycles, then DatenWahl=1, RegisterSchreiben=1. Store -> SpeicherSchreiben=1, RegisterSchreiben=0.
- PC=10, Bez, IDaten=32'hFFFFFFFC: Quellwert1=0 -> PC=6; Quellwert1=5 -> PC=11. BNez mirrors. JAL, PC=10, IDaten=3 -> DatenWahl=2, RegisterSchreiben=1, PC=13. Jreg, Quellwert1=32'h40 -> PC=32'h40, no write.
- MEM_TIMEOUT=4, SpeicherBereit held 0 in HOLEN -> Fehler=1 after 4 wait cycles, SpeicherAnfrage=0, PC unchanged. SpeicherBereit=1 on the 4th wait cycle -> no error.
- Reset pulsed mid-SPEICHER (non-aligned to Takt) -> outputs 0 immediately, PC=RESET_PC, no RegisterSchreiben. Anhalten=1 during AUSFUEHREN -> instruction completes, then stays in LEERLAUF with no request.
